// File: rtl/sync_fifo_lvl_if.sv
// ============================================================================
// sync_fifo_lvl_if : handshake/status bundle between sync_fifo_lvl and its users
// Rev 1.0
// ============================================================================
`default_nettype none

interface sync_fifo_lvl_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int c_LVL_W = $clog2(DEPTH) + 1;

  logic               flush;
  logic               clr_err;
  logic               write_en;
  logic [WIDTH-1:0]   din;
  logic               read_en;
  logic [WIDTH-1:0]   dout;
  logic               dout_valid;
  logic               full;
  logic               empty;
  logic               almost_full;
  logic               almost_empty;
  logic [c_LVL_W-1:0] level;
  logic               overflow;
  logic               underflow;

  modport master (
    output flush, clr_err, write_en, din, read_en,
    input  dout, dout_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  flush, clr_err, write_en, din, read_en,
    output dout, dout_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );
endinterface

`default_nettype wire

// File: rtl/sync_fifo_lvl.sv
// ============================================================================
// sync_fifo_lvl : single-clock FIFO with fill level, thresholds, sticky errors
// and flush. Define SYNC_FIFO_FWFT_EN for first-word-fall-through output.
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_fifo_lvl #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  wire logic       CLK,
  input  wire logic       rstn,
  sync_fifo_lvl_if.slave  bus
);

  localparam int                 c_PTR_W   = $clog2(DEPTH);
  localparam int                 c_LVL_W   = c_PTR_W + 1;
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
  localparam logic [c_LVL_W-1:0] c_LVL_ONE = c_LVL_W'(1);
  localparam logic [c_LVL_W-1:0] c_LVL_MAX = c_LVL_W'(DEPTH);
  localparam logic [c_LVL_W-1:0] c_AF_LVL  = c_LVL_W'(AF_THRESH);
  localparam logic [c_LVL_W-1:0] c_AE_LVL  = c_LVL_W'(AE_THRESH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_LVL_W-1:0] level_q, level_d;
  logic               full_q, empty_q, af_q, ae_q;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               w_rd_acc, w_wr_acc, w_mem_we;

  // Accept decisions use registered flags only; a full FIFO takes a write
  // only when a pop frees the slot at the same edge.
  always_comb begin
    w_rd_acc = bus.read_en & ~empty_q;
    w_wr_acc = bus.write_en & (~full_q | w_rd_acc);
    w_mem_we = w_wr_acc & ~bus.flush;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (w_wr_acc) wr_ptr_d = wr_ptr_q + c_PTR_ONE;
      if (w_rd_acc) rd_ptr_d = rd_ptr_q + c_PTR_ONE;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   level_d = level_q + c_LVL_ONE;
        2'b01:   level_d = level_q - c_LVL_ONE;
        default: level_d = level_q;
      endcase
      // New errors win over a coincident clear.
      ovf_d = (bus.write_en & ~w_wr_acc) | (ovf_q & ~bus.clr_err);
      unf_d = (bus.read_en  & ~w_rd_acc) | (unf_q & ~bus.clr_err);
    end
  end

  always_ff @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= (level_d == c_LVL_MAX);
      empty_q  <= (level_d == '0);
      af_q     <= (level_d >= c_AF_LVL);
      ae_q     <= (level_d <= c_AE_LVL);
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (w_mem_we) mem_q[wr_ptr_q] <= bus.din;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.dout       = empty_q ? '0 : mem_q[rd_ptr_q];
  assign bus.dout_valid = ~empty_q;
`else
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;

  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = w_rd_acc & ~bus.flush;
    if (dout_valid_d) dout_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
`endif

  assign bus.level        = level_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_lvl.sv
// ============================================================================
// tb_sync_fifo_lvl : directed vector bench for sync_fifo_lvl (DEPTH 8, AF 6, AE 2)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sync_fifo_lvl;

  typedef struct {
    logic        fl, ce, we;
    logic [15:0] din;
    logic        re;
    logic [15:0] dout;
    logic        dv, full, empty, af, ae;
    logic [3:0]  lvl;
    logic        ovf, unf;
  } vec_t;

  logic CLK;
  logic rstn;
  int   n_pass;
  int   n_total;
  vec_t vq[$];

  sync_fifo_lvl_if #(.WIDTH(16), .DEPTH(8)) bus ();

  sync_fifo_lvl #(
    .WIDTH(16), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)
  ) dut (
    .CLK  (CLK),
    .rstn (rstn),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic void add(input logic fl, ce, we, input logic [15:0] din,
                              input logic re, input logic [15:0] dout,
                              input logic dv, full, empty, af, ae,
                              input logic [3:0] lvl, input logic ovf, unf);
    vec_t v;
    v.fl = fl; v.ce = ce; v.we = we; v.din = din; v.re = re;
    v.dout = dout; v.dv = dv; v.full = full; v.empty = empty;
    v.af = af; v.ae = ae; v.lvl = lvl; v.ovf = ovf; v.unf = unf;
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [9:0] flags();
    return {bus.full, bus.empty, bus.almost_full, bus.almost_empty,
            bus.level, bus.overflow, bus.underflow};
  endfunction

  task automatic drive(input logic fl, ce, we, input logic [15:0] din, input logic re);
    bus.flush = fl; bus.clr_err = ce; bus.write_en = we; bus.din = din; bus.read_en = re;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rstn = 1'b0;
    drive(0, 0, 0, 16'h0, 0);

    // Fill with even values past full (fields: fl ce we din re | dout dv full empty af ae lvl ovf unf)
    add(0,0,1,16'd0 ,0, 16'h0,0, 0,0,0,1, 4'd1,0,0);
    add(0,0,1,16'd2 ,0, 16'h0,0, 0,0,0,1, 4'd2,0,0);
    add(0,0,1,16'd4 ,0, 16'h0,0, 0,0,0,0, 4'd3,0,0);
    add(0,0,1,16'd6 ,0, 16'h0,0, 0,0,0,0, 4'd4,0,0);
    add(0,0,1,16'd8 ,0, 16'h0,0, 0,0,0,0, 4'd5,0,0);
    add(0,0,1,16'd10,0, 16'h0,0, 0,0,1,0, 4'd6,0,0);
    add(0,0,1,16'd12,0, 16'h0,0, 0,0,1,0, 4'd7,0,0);
    add(0,0,1,16'd14,0, 16'h0,0, 1,0,1,0, 4'd8,0,0);
    add(0,0,1,16'd16,0, 16'h0,0, 1,0,1,0, 4'd8,1,0);
    add(0,0,1,16'd18,0, 16'h0,0, 1,0,1,0, 4'd8,1,0);
    add(0,0,1,16'd20,0, 16'h0,0, 1,0,1,0, 4'd8,1,0);
    add(0,0,1,16'd22,0, 16'h0,0, 1,0,1,0, 4'd8,1,0);
    add(0,0,1,16'd24,0, 16'h0,0, 1,0,1,0, 4'd8,1,0);
    add(0,0,1,16'd26,0, 16'h0,0, 1,0,1,0, 4'd8,1,0);
    add(0,0,1,16'd28,0, 16'h0,0, 1,0,1,0, 4'd8,1,0);
    // Drain one read every other cycle, then one read too many
    add(0,0,0,16'h0,1, 16'd0 ,1, 0,0,1,0, 4'd7,1,0);
    add(0,0,0,16'h0,0, 16'd0 ,0, 0,0,1,0, 4'd7,1,0);
    add(0,0,0,16'h0,1, 16'd2 ,1, 0,0,1,0, 4'd6,1,0);
    add(0,0,0,16'h0,0, 16'd2 ,0, 0,0,1,0, 4'd6,1,0);
    add(0,0,0,16'h0,1, 16'd4 ,1, 0,0,0,0, 4'd5,1,0);
    add(0,0,0,16'h0,0, 16'd4 ,0, 0,0,0,0, 4'd5,1,0);
    add(0,0,0,16'h0,1, 16'd6 ,1, 0,0,0,0, 4'd4,1,0);
    add(0,0,0,16'h0,0, 16'd6 ,0, 0,0,0,0, 4'd4,1,0);
    add(0,0,0,16'h0,1, 16'd8 ,1, 0,0,0,0, 4'd3,1,0);
    add(0,0,0,16'h0,0, 16'd8 ,0, 0,0,0,0, 4'd3,1,0);
    add(0,0,0,16'h0,1, 16'd10,1, 0,0,0,1, 4'd2,1,0);
    add(0,0,0,16'h0,0, 16'd10,0, 0,0,0,1, 4'd2,1,0);
    add(0,0,0,16'h0,1, 16'd12,1, 0,0,0,1, 4'd1,1,0);
    add(0,0,0,16'h0,0, 16'd12,0, 0,0,0,1, 4'd1,1,0);
    add(0,0,0,16'h0,1, 16'd14,1, 0,1,0,1, 4'd0,1,0);
    add(0,0,0,16'h0,0, 16'd14,0, 0,1,0,1, 4'd0,1,0);
    add(0,0,0,16'h0,1, 16'd14,0, 0,1,0,1, 4'd0,1,1);
    add(0,1,0,16'h0,0, 16'd14,0, 0,1,0,1, 4'd0,0,0);
    // Write+read on empty: write taken, read dropped; set wins over clear
    add(0,0,1,16'h55,1, 16'd14,0, 0,0,0,1, 4'd1,0,1);
    add(0,1,0,16'h0 ,0, 16'd14,0, 0,0,0,1, 4'd1,0,0);
    add(0,0,0,16'h0 ,1, 16'h55,1, 0,1,0,1, 4'd0,0,0);
    add(0,1,0,16'h0 ,1, 16'h55,0, 0,1,0,1, 4'd0,0,1);
    add(0,1,0,16'h0 ,0, 16'h55,0, 0,1,0,1, 4'd0,0,0);
    // Fill, then write+read while full, then drain back-to-back
    add(0,0,1,16'h10,0, 16'h55,0, 0,0,0,1, 4'd1,0,0);
    add(0,0,1,16'h11,0, 16'h55,0, 0,0,0,1, 4'd2,0,0);
    add(0,0,1,16'h12,0, 16'h55,0, 0,0,0,0, 4'd3,0,0);
    add(0,0,1,16'h13,0, 16'h55,0, 0,0,0,0, 4'd4,0,0);
    add(0,0,1,16'h14,0, 16'h55,0, 0,0,0,0, 4'd5,0,0);
    add(0,0,1,16'h15,0, 16'h55,0, 0,0,1,0, 4'd6,0,0);
    add(0,0,1,16'h16,0, 16'h55,0, 0,0,1,0, 4'd7,0,0);
    add(0,0,1,16'h17,0, 16'h55,0, 1,0,1,0, 4'd8,0,0);
    add(0,0,1,16'hAAAA,1, 16'h10,1, 1,0,1,0, 4'd8,0,0);
    add(0,0,0,16'h0,1, 16'h11  ,1, 0,0,1,0, 4'd7,0,0);
    add(0,0,0,16'h0,1, 16'h12  ,1, 0,0,1,0, 4'd6,0,0);
    add(0,0,0,16'h0,1, 16'h13  ,1, 0,0,0,0, 4'd5,0,0);
    add(0,0,0,16'h0,1, 16'h14  ,1, 0,0,0,0, 4'd4,0,0);
    add(0,0,0,16'h0,1, 16'h15  ,1, 0,0,0,0, 4'd3,0,0);
    add(0,0,0,16'h0,1, 16'h16  ,1, 0,0,0,1, 4'd2,0,0);
    add(0,0,0,16'h0,1, 16'h17  ,1, 0,0,0,1, 4'd1,0,0);
    add(0,0,0,16'h0,1, 16'hAAAA,1, 0,1,0,1, 4'd0,0,0);
    // Level 5, flush with write; flush with read on empty; then reuse
    add(0,0,1,16'h21,0, 16'hAAAA,0, 0,0,0,1, 4'd1,0,0);
    add(0,0,1,16'h22,0, 16'hAAAA,0, 0,0,0,1, 4'd2,0,0);
    add(0,0,1,16'h23,0, 16'hAAAA,0, 0,0,0,0, 4'd3,0,0);
    add(0,0,1,16'h24,0, 16'hAAAA,0, 0,0,0,0, 4'd4,0,0);
    add(0,0,1,16'h25,0, 16'hAAAA,0, 0,0,0,0, 4'd5,0,0);
    add(1,0,1,16'h99,0, 16'hAAAA,0, 0,1,0,1, 4'd0,0,0);
    add(1,0,0,16'h0 ,1, 16'hAAAA,0, 0,1,0,1, 4'd0,0,0);
    add(0,0,1,16'h1234,0, 16'hAAAA,0, 0,0,0,1, 4'd1,0,0);
    add(0,0,0,16'h0   ,1, 16'h1234,1, 0,1,0,1, 4'd0,0,0);
    // Build level 3 with a fresh pop before the asynchronous reset
    add(0,0,1,16'h31,0, 16'h1234,0, 0,0,0,1, 4'd1,0,0);
    add(0,0,1,16'h32,0, 16'h1234,0, 0,0,0,1, 4'd2,0,0);
    add(0,0,1,16'h33,0, 16'h1234,0, 0,0,0,0, 4'd3,0,0);
    add(0,0,1,16'h34,0, 16'h1234,0, 0,0,0,0, 4'd4,0,0);
    add(0,0,0,16'h0 ,1, 16'h31  ,1, 0,0,0,0, 4'd3,0,0);

    #12;
    check("reset flags", {22'd0, flags()}, {22'd0, 10'b0101_0000_00});
    check("reset dout", {15'd0, bus.dout_valid, bus.dout}, 32'd0);
    rstn = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].fl, vq[i].ce, vq[i].we, vq[i].din, vq[i].re);
      @(posedge CLK);
      #1;
      check($sformatf("vec%0d flags", i), {22'd0, flags()},
            {22'd0, vq[i].full, vq[i].empty, vq[i].af, vq[i].ae, vq[i].lvl, vq[i].ovf, vq[i].unf});
`ifndef SYNC_FIFO_FWFT_EN
      check($sformatf("vec%0d dout", i), {15'd0, bus.dout_valid, bus.dout},
            {15'd0, vq[i].dv, vq[i].dout});
`endif
    end
    drive(0, 0, 0, 16'h0, 0);

    // Asynchronous reset between edges, level 3 and dout_valid high
    #2;
    rstn = 1'b0;
    #1;
    check("async rst flags", {22'd0, flags()}, {22'd0, 10'b0101_0000_00});
    check("async rst dout", {15'd0, bus.dout_valid, bus.dout}, 32'd0);
    #3;
    rstn = 1'b1;

    drive(0, 0, 1, 16'h0042, 0);
    @(posedge CLK);
    #1;
    drive(0, 0, 0, 16'h0, 0);
    check("post-rst write lvl", {28'd0, bus.level}, 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
    check("fwft head", {15'd0, bus.dout_valid, bus.dout}, {15'd0, 1'b1, 16'h0042});
    @(posedge CLK);
    #1;
    check("fwft hold", {15'd0, bus.dout_valid, bus.dout}, {15'd0, 1'b1, 16'h0042});
    drive(0, 0, 0, 16'h0, 1);
    @(posedge CLK);
    #1;
    drive(0, 0, 0, 16'h0, 0);
    check("fwft pop", {15'd0, bus.dout_valid, bus.dout}, 32'd0);
`else
    check("no-read dout", {15'd0, bus.dout_valid, bus.dout}, 32'd0);
    drive(0, 0, 0, 16'h0, 1);
    @(posedge CLK);
    #1;
    drive(0, 0, 0, 16'h0, 0);
    check("post-rst read", {15'd0, bus.dout_valid, bus.dout}, {15'd0, 1'b1, 16'h0042});
`endif
    check("final empty", {31'd0, bus.empty}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sync_fifo_lvl.md
Name: sync_fifo_lvl

Overview:
Single-clock, parametrised FIFO that follows on from the dual-clock FIFO. It keeps the write_en/read_en/full/empty handshake and adds:
- a fill-level output
- programmable almost-full and almost-empty thresholds
- sticky overflow and underflow error flags
- a synchronous flush

It sits between same-clock producer/consumer blocks where CDC is not needed.

Parameters:
WIDTH, 16, data word width in bits.
DEPTH, 8, number of entries; must be a power of 2, minimum 2.
AF_THRESH, 6, almost_full asserts when level >= AF_THRESH; legal range 1..DEPTH.
AE_THRESH, 2, almost_empty asserts when level <= AE_THRESH; legal range 0..DEPTH-1.

Ports:
CLK  input  1  single clock; all logic is on the rising edge.
rstn  input  1  asynchronous, active-low reset.
flush  input  1  synchronous clear of contents and pointers; has priority over read/write.
clr_err  input  1  synchronous clear of overflow/underflow.
write_en  input  1  write request.
din  input  WIDTH  write data.
read_en  input  1  read request.
dout  output  WIDTH  read data.
dout_valid  output  1  dout holds a newly popped word.
full  output  1  level == DEPTH.
empty  output  1  level == 0.
almost_full  output  1  level >= AF_THRESH.
almost_empty  output  1  level <= AE_THRESH.
level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
overflow  output  1  sticky: a write was dropped.
underflow  output  1  sticky: a read was dropped.

Behaviour:
- Reset (rstn low, asynchronous) sets:
  - dout=0, dout_valid=0, level=0
  - empty=1, full=0, almost_empty=1, almost_full=0
  - overflow=0, underflow=0
  - pointers cleared
  - Memory contents are not reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. level is a separate counter.
- Accept rules, evaluated on registered state at the clock edge:
  - rd_acc = read_en & !empty.
  - wr_acc = write_en & (!full | rd_acc). A write into a full FIFO is accepted only when a read pops in the same cycle.
  - A read on an empty FIFO is dropped even if a write occurs in the same cycle; there is no bypass.
- Level update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither occur.
- All flags are registered and derived from the next level, so they are valid in the same cycle as level.
- Read latency (default mode): on rd_acc, dout is loaded with mem[rd_ptr] at that edge and dout_valid=1 for exactly one cycle. dout holds its value otherwise.
- Write-to-read: a word written at edge N is readable (empty=0) after edge N. A read request in cycle N+1 produces dout at edge N+1.
- Error flags:
  - overflow sets on write_en & !wr_acc.
  - underflow sets on read_en & !rd_acc.
  - Both stay set until clr_err or reset.
  - If clr_err coincides with a new error, the flag stays set (set wins).
- flush:
  - Clears the pointers and level; flags take their empty-state values; dout_valid is cleared.
  - Any read/write in the same cycle is ignored and does not raise an error.
  - dout and the error flags are not changed.
- Reset asserted mid-operation takes effect immediately (asynchronous). Data in flight is lost.

Optional Feature:
Macro SYNC_FIFO_FWFT_EN selects first-word-fall-through mode.
- Defined:
  - dout presents mem[rd_ptr] whenever empty=0, from the same edge that clears empty.
  - read_en pops the head word; the next word (if any) appears after that edge.
  - dout_valid = !empty.
  - dout is 0 while empty.
  - Accept and error rules are unchanged.
- Undefined: the default 1-cycle registered-read behaviour described above.

Test Plan:
1. Reset, then write 0,2,4,...,28 (15 writes, read_en=0), DEPTH=8 -> full=1 after the 8th write, level=8, almost_full=1 from level 6; overflow=1 after the 9th write; words 0..14 are not all stored, only 0..14 step 2 up to 14.
2. From full, pop 8 words at one read every other cycle -> dout sequence 0,2,...,14, each with a single-cycle dout_valid; empty=1 after the 8th pop; an extra read sets underflow=1 and dout stays 14.
3. Full FIFO with write_en=1 and read_en=1 in the same cycle, din=0xAAAA -> both accepted, level stays 8, overflow stays 0; 0xAAAA is read out last.
4. Empty FIFO with write_en=1 and read_en=1 in the same cycle -> write accepted, read dropped, level=1, underflow=1; clr_err clears underflow the next cycle.
5. Level 5 with flush=1 and write_en=1 -> level=0, empty=1, almost_empty=1, no overflow; then write 0x1234 and read -> dout=0x1234.
6. Assert rstn=0 between clock edges with level 3 -> all outputs take their reset values immediately; with SYNC_FIFO_FWFT_EN, after one write of 0x0042, dout=0x0042 and dout_valid=1 with no read issued.
